// File: rtl/obi_resp_pkg.sv
// Shared types and constants for the OBI data responder and its response queue.
package obi_resp_pkg;

  // One queued response: read data plus error flag.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_entry_t;

  localparam int RESP_W = $bits(resp_entry_t);

  // Grant handshake states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // The only supported atomic opcode: a plain load/store.
  localparam logic [5:0] ATOP_NONE = 6'h0;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// Response queue: holds {rdata, err} entries in grant order until they are
// presented on the response channel. Push is dropped when full, pop when empty.
module obi_resp_fifo
  import obi_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RESP_W-1:0] push_data,
  input  logic              pop,
  output logic [RESP_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [RESP_W-1:0] slots [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Occupancy and pointer bookkeeping; a simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/obi_data_responder.sv
// OBI data-side responder: word-addressed memory with byte-enable writes,
// optional grant stall, and an in-order response queue.
module obi_data_responder
  import obi_resp_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int GNT_STALL  = 0,
  parameter int RESP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic [5:0]  data_atop_i,
  input  logic        resp_hold_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  // Any address bit at or above the top of the memory marks the access out of range.
  localparam logic [31:0] RANGE_MASK = ~((32'(MEM_WORDS) << 2) - 32'd1);
  localparam int CW = (GNT_STALL > 1) ? $clog2(GNT_STALL) : 1;

  logic [31:0]       mem [MEM_WORDS];
  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              gnt;
  logic              accept;
  logic              bad;
  logic [AW-1:0]     idx;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;
  logic [RESP_W-1:0] head_bits;
  logic              q_full;
  logic              q_empty;

  assign idx    = data_addr_i[AW+1:2];
  assign bad    = (data_atop_i != ATOP_NONE) || ((data_addr_i & RANGE_MASK) != 32'd0);
  assign accept = gnt;

  // Grant FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Grant decision: immediate when no stall is configured, otherwise after the
  // stall count expires; an abandoned request drops back to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt        = 1'b0;
    case (state)
      IDLE: begin
        if (data_req_i) begin
          if (GNT_STALL == 0) begin
            gnt = !q_full;
          end else begin
            state_next = STALL;
            cnt_next   = CW'(GNT_STALL - 1);
          end
        end
      end
      STALL: begin
        if (!data_req_i) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          if (!q_full) begin
            gnt        = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (rst) gnt = 1'b0;
  end

  assign data_gnt_o = gnt;

  // Response entry captured at the grant edge; reads sample the whole word.
  always_comb begin
    push_entry.rdata = 32'd0;
    push_entry.err   = bad;
    if (!bad && !data_we_i) push_entry.rdata = mem[idx];
  end

  // Memory: cleared by reset, byte-merged on accepted, error-free writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (accept && data_we_i && !bad) begin
      mem[idx] <= merge_bytes(mem[idx], data_wdata_i, data_be_i);
    end
  end

  obi_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (data_rvalid_o),
    .head      (head_bits),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign head_entry    = head_bits;
  assign data_rvalid_o = !q_empty && !resp_hold_i && !rst;
  assign data_rdata_o  = data_rvalid_o ? head_entry.rdata : 32'd0;
  assign data_err_o    = data_rvalid_o ? head_entry.err : 1'b0;

endmodule

// File: doc/obi_data_responder.md
OBI_DATA_RESPONDER -- requirements
Module: obi_data_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit memory words; power of two.
REQ-002 SHALL have parameter GNT_STALL, default 0: cycles the grant is withheld after a new request is seen.
REQ-003 SHALL have parameter RESP_DEPTH, default 2: response queue depth, i.e. the maximum number of outstanding transactions.
REQ-004 SHALL have port: clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: data_req_i  in  1  initiator request.
REQ-007 SHALL have port: data_gnt_o  out  1  request accepted this cycle.
REQ-008 SHALL have port: data_addr_i  in  32  byte address.
REQ-009 SHALL have port: data_we_i  in  1  1 = write, 0 = read.
REQ-010 SHALL have port: data_be_i  in  4  byte enables.
REQ-011 SHALL have port: data_wdata_i  in  32  write data.
REQ-012 SHALL have port: data_atop_i  in  6  atomic opcode; only 0 is supported.
REQ-013 SHALL have port: resp_hold_i  in  1  test control; suppresses responses while high.
REQ-014 SHALL have port: data_rvalid_o  out  1  response valid.
REQ-015 SHALL have port: data_rdata_o  out  32  read data.
REQ-016 SHALL have port: data_err_o  out  1  response error.

Function
REQ-017 SHALL accept a transaction exactly in a cycle where data_req_i && data_gnt_o.
REQ-018 SHALL implement an FSM with states IDLE and STALL:
- IDLE + data_req_i + GNT_STALL>0 -> STALL; load stall counter with GNT_STALL-1.
- STALL: decrement the counter each cycle.
- STALL + counter==0 + queue not full -> assert data_gnt_o and return to IDLE.
REQ-019 SHALL, when GNT_STALL==0, drive data_gnt_o = data_req_i && !queue_full combinationally in IDLE.
REQ-020 SHALL never assert data_gnt_o while the queue is full, even if a pop occurs in the same cycle.
REQ-021 SHALL use word index data_addr_i[log2(MEM_WORDS)+1:2]; data_addr_i[1:0] is ignored.
REQ-022 SHALL flag an address with any bit above log2(MEM_WORDS)+1 set as out of range.
REQ-023 SHALL, on an accepted write, update each byte whose data_be_i bit is set at the grant edge.
REQ-024 SHALL, on an accepted read, capture the full addressed word at the grant edge, independent of data_be_i.
REQ-025 SHALL treat data_atop_i != 0 or an out-of-range address as an error:
- no memory update;
- response rdata = 0 and err = 1.
REQ-026 SHALL push a {rdata, err} entry at the grant edge (writes push rdata = 0, err = 0).
REQ-027 SHALL assert data_rvalid_o for the queue head whenever the queue is non-empty and resp_hold_i == 0, then pop it that cycle; the earliest rvalid is 1 cycle after grant.
REQ-028 SHALL issue responses strictly in grant order, one per cycle.
REQ-029 SHALL allow a simultaneous push and pop, leaving the occupancy unchanged.
REQ-030 SHALL drive data_rdata_o = 0 and data_err_o = 0 whenever data_rvalid_o == 0.
REQ-031 SHALL keep data_req_i deasserting without a grant legal: the FSM returns to IDLE and the counter is cleared.

Reset
REQ-032 SHALL, while rst is high at a clock edge:
- set the FSM to IDLE and the stall counter to 0;
- empty the queue, discarding any outstanding responses;
- clear all memory words to 0.
REQ-033 SHALL force data_gnt_o = 0, data_rvalid_o = 0, data_rdata_o = 0 and data_err_o = 0 during and immediately after reset.
REQ-034 SHALL ignore any request present while rst is high; no grant is given.

Structure
REQ-035 SHALL define in package obi_resp_pkg:
- resp_entry_t struct {rdata[31:0], err};
- state_t enum {IDLE, STALL};
- constant ATOP_NONE = 6'h0.
REQ-036 SHALL implement the response queue as sub-module obi_resp_fifo, parameterised by depth, with push/pop/full/empty.

Verification
REQ-037 SHALL cover: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> read gnt same cycle; rvalid next cycle; rdata = 0xDEADBEEF; err = 0.
REQ-038 SHALL cover: after REQ-037, write 0x000000AA to 0x10 with be=4'b0001, then read 0x10 -> rdata = 0xDEADBEAA.
REQ-039 SHALL cover: GNT_STALL=3 with req held -> gnt asserted on the 4th cycle of req; rvalid 1 cycle after gnt.
REQ-040 SHALL cover: resp_hold_i=1 with 3 back-to-back reads -> 2 grants, gnt low on the 3rd; releasing hold -> 2 consecutive rvalids in order, then 3rd grant.
REQ-041 SHALL cover: read 0x0000_0400 with MEM_WORDS=256, or atop=6'h02 -> rvalid with err = 1 and rdata = 0; a following read of that word returns the unchanged value.
REQ-042 SHALL cover: rst asserted with 2 responses queued -> no rvalid after reset; read 0x10 returns 0.
